// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer for the remaining game time.
// Loads a start value and decrements it once per CLOCK_FREQUENCY cycles
// while running. It can be paused and resumed, and it flags expiry at 00.
//
// Ports:
//   ClockIn      - system clock
//   Resetn       - synchronous reset, active-low
//   Load         - 1-cycle command: load LoadTens/LoadOnes (clamped to 9), go IDLE
//   LoadTens     - BCD tens digit for Load
//   LoadOnes     - BCD ones digit for Load
//   Start        - 1-cycle command: start from IDLE, or resume from PAUSED
//   Pause        - 1-cycle command: freeze the countdown while in RUN
//   TensValue    - current tens digit
//   OnesValue    - current ones digit
//   game_timer   - {TensValue, OnesValue}
//   Running      - high while in RUN
//   SecondTick   - 1-cycle pulse after each decrement
//   TimeUp       - high while in EXPIRED
//   TimeUpPulse  - 1-cycle pulse on entry to EXPIRED
module countdown_timer #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned START_TENS      = 6,
    parameter int unsigned START_ONES      = 0
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [3:0] LoadTens,
    input  logic [3:0] LoadOnes,
    input  logic       Start,
    input  logic       Pause,
    output logic [3:0] TensValue,
    output logic [3:0] OnesValue,
    output logic [7:0] game_timer,
    output logic       Running,
    output logic       SecondTick,
    output logic       TimeUp,
    output logic       TimeUpPulse
);

    localparam int unsigned PRESC_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(CLOCK_FREQUENCY - 1);
    localparam logic [3:0] RST_TENS = 4'(START_TENS);
    localparam logic [3:0] RST_ONES = 4'(START_ONES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [3:0]         tens_q,    tens_d;
    logic [3:0]         ones_q,    ones_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic               running_q, running_d;
    logic               tick_q,    tick_d;
    logic               timeup_q,  timeup_d;
    logic               pulse_q,   pulse_d;

    logic [3:0]         dec_tens_c;
    logic [3:0]         dec_ones_c;

    // Load digits above 9 are clamped so the display never shows non-BCD values
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // BCD decrement with borrow. In RUN the value is never 00, so tens never underflows.
    always_comb begin
        dec_tens_c = tens_q;
        dec_ones_c = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_ones_c = 4'd9;
            dec_tens_c = tens_q - 4'd1;
        end
    end

    // Next-state logic. Command priority is Load > Start > Pause.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        pulse_d = 1'b0;

        if (Load) begin
            tens_d  = clamp_bcd(LoadTens);
            ones_d  = clamp_bcd(LoadOnes);
            presc_d = PRESC_RELOAD;
            state_d = S_IDLE;
        end else if (Start && (state_q == S_IDLE)) begin
            if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
                state_d = S_EXPIRED;
                pulse_d = 1'b1;
            end else begin
                presc_d = PRESC_RELOAD;
                state_d = S_RUN;
            end
        end else if (Start && (state_q == S_PAUSED)) begin
            // Resume: the prescaler keeps its frozen value
            state_d = S_RUN;
        end else if (Pause && (state_q == S_RUN)) begin
            state_d = S_PAUSED;
        end else if (state_q == S_RUN) begin
            if (presc_q == '0) begin
                tens_d  = dec_tens_c;
                ones_d  = dec_ones_c;
                presc_d = PRESC_RELOAD;
                tick_d  = 1'b1;
                if ((dec_tens_c == 4'd0) && (dec_ones_c == 4'd0)) begin
                    state_d = S_EXPIRED;
                    pulse_d = 1'b1;
                end
            end else begin
                presc_d = presc_q - PRESC_W'(1);
            end
        end

        // Status levels are registered copies of the next state
        running_d = (state_d == S_RUN);
        timeup_d  = (state_d == S_EXPIRED);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            tens_q    <= RST_TENS;
            ones_q    <= RST_ONES;
            presc_q   <= PRESC_RELOAD;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            timeup_q  <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            timeup_q  <= timeup_d;
            pulse_q   <= pulse_d;
        end
    end

    assign TensValue   = tens_q;
    assign OnesValue   = ones_q;
    assign game_timer  = {tens_q, ones_q};
    assign Running     = running_q;
    assign SecondTick  = tick_q;
    assign TimeUp      = timeup_q;
    assign TimeUpPulse = pulse_q;

endmodule
